// File: rtl/io_pkg.sv
// Shared I/O address map for the memory-mapped input and output port blocks.
// Both blocks decode the word index taken from addr[7:2].
package io_pkg;

    localparam int IO_DATA_W    = 32;
    localparam int IO_NUM_IN    = 3;
    localparam int IO_DBC_CNT_W = 16;

    localparam logic [5:0] IO_OUT0_IDX = 6'b100000;
    localparam logic [5:0] IO_OUT1_IDX = 6'b100001;
    localparam logic [5:0] IO_OUT2_IDX = 6'b100010;

    localparam logic [5:0] IO_IN0_IDX  = 6'b110000;
    localparam logic [5:0] IO_IN1_IDX  = 6'b110001;
    localparam logic [5:0] IO_IN2_IDX  = 6'b110010;
    localparam logic [5:0] IO_STAT_IDX = 6'b110011;

    typedef enum logic [2:0] {
        RD_NONE,
        RD_PORT0,
        RD_PORT1,
        RD_PORT2,
        RD_STAT
    } rd_sel_e;

    function automatic rd_sel_e decode_rd(input logic [5:0] idx);
        rd_sel_e sel;
        case (idx)
            IO_IN0_IDX:  sel = RD_PORT0;
            IO_IN1_IDX:  sel = RD_PORT1;
            IO_IN2_IDX:  sel = RD_PORT2;
            IO_STAT_IDX: sel = RD_STAT;
            default:     sel = RD_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// Per-port two-flop synchroniser plus whole-word debouncer with a one-cycle accept pulse.
// IO_INPUT_DEBOUNCE_EN selects the debounce filter; otherwise the synchronised value is taken directly.
module io_debounce
    import io_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] value_o,
    output logic             accept_o
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_cfg
        $error("io_debounce: DEBOUNCE_CYCLES must be within 2..65535");
    end

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] stable_q, stable_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef IO_INPUT_DEBOUNCE_EN
    localparam logic [IO_DBC_CNT_W-1:0] CNT_LAST = IO_DBC_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]        cand_q, cand_d;
    logic [IO_DBC_CNT_W-1:0] cnt_q, cnt_d;
    logic                    accept;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        accept   = 1'b0;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
            // Counter saturates here; a new stable value is accepted only once.
            if (stable_q != cand_q) begin
                stable_d = cand_q;
                accept   = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign accept_o = accept;
`else
    assign stable_d = sync2_q;
    assign accept_o = (sync2_q != stable_q);

    always_ff @(posedge clk_i) begin
        if (reset_i) stable_q <= '0;
        else         stable_q <= stable_d;
    end
`endif

    // Value the port holds after this edge, so a read on the accepting edge sees the new word.
    assign value_o = stable_d;

endmodule

// File: rtl/io_input.sv
// Memory-mapped input-port reader: three debounced ports, sticky change flags and a registered read path.
// Define IO_INPUT_DEBOUNCE_EN to enable the debounce filter in each port.
module io_input
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        io_clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        read_io_enable,
    input  logic [31:0] in_port0,
    input  logic [31:0] in_port1,
    input  logic [31:0] in_port2,
    output logic [31:0] dataout,
    output logic        data_valid,
    output logic [2:0]  changed
);

    logic [IO_DATA_W-1:0] port_in  [IO_NUM_IN];
    logic [IO_DATA_W-1:0] port_val [IO_NUM_IN];
    logic [IO_NUM_IN-1:0] accept;

    assign port_in[0] = in_port0;
    assign port_in[1] = in_port1;
    assign port_in[2] = in_port2;

    for (genvar i = 0; i < IO_NUM_IN; i++) begin : g_port
        io_debounce #(
            .WIDTH           (IO_DATA_W),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_i    (io_clk),
            .reset_i  (reset),
            .in_i     (port_in[i]),
            .value_o  (port_val[i]),
            .accept_o (accept[i])
        );
    end

    logic unused_addr;
    assign unused_addr = ^{addr[31:8], addr[1:0]};

    rd_sel_e              rd_sel;
    logic [IO_DATA_W-1:0] rdata;
    logic [IO_NUM_IN-1:0] changed_q, changed_d;
    logic [IO_DATA_W-1:0] dataout_q;
    logic                 data_valid_q;

    always_comb begin
        rd_sel = decode_rd(addr[7:2]);
        rdata  = '0;
        case (rd_sel)
            RD_PORT0: rdata = port_val[0];
            RD_PORT1: rdata = port_val[1];
            RD_PORT2: rdata = port_val[2];
            RD_STAT:  rdata = {{(IO_DATA_W-IO_NUM_IN){1'b0}}, changed_q};
            default:  rdata = '0;
        endcase
        // A status read clears the flags, but an acceptance on the same edge re-sets its bit.
        changed_d = changed_q;
        if (read_io_enable && rd_sel == RD_STAT) changed_d = '0;
        changed_d = changed_d | accept;
    end

    always_ff @(posedge io_clk) begin
        if (reset) begin
            changed_q    <= '0;
            dataout_q    <= '0;
            data_valid_q <= 1'b0;
        end else begin
            changed_q    <= changed_d;
            data_valid_q <= read_io_enable;
            if (read_io_enable) dataout_q <= rdata;
        end
    end

    assign dataout    = dataout_q;
    assign data_valid = data_valid_q;
    assign changed    = changed_q;

endmodule

// File: tb/tb_io_input.sv
// Self-checking bench for io_input: read data is scoreboarded, flags and timing are checked per scenario.
// Expected change latency follows IO_INPUT_DEBOUNCE_EN when the bench is built with it.
module tb_io_input;

`ifdef IO_INPUT_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif
    localparam int DBC = 16;
    localparam int LAT = DEB ? DBC + 2 : 2;

    logic        io_clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic        read_io_enable = 1'b0;
    logic [31:0] in_port0 = '0;
    logic [31:0] in_port1 = '0;
    logic [31:0] in_port2 = '0;
    logic [31:0] dataout;
    logic        data_valid;
    logic [2:0]  changed;

    int checks = 0;
    int errors = 0;
    int n_strobe = 0;
    int n_valid = 0;
    logic [31:0] sb[$];

    io_input #(.DEBOUNCE_CYCLES(DBC)) dut (
        .io_clk         (io_clk),
        .reset          (reset),
        .addr           (addr),
        .read_io_enable (read_io_enable),
        .in_port0       (in_port0),
        .in_port1       (in_port1),
        .in_port2       (in_port2),
        .dataout        (dataout),
        .data_valid     (data_valid),
        .changed        (changed)
    );

    always #5 io_clk = ~io_clk;

    // Scoreboard: every data_valid pulse must match the oldest pending read.
    always @(posedge io_clk) begin
        logic [31:0] exp_d;
        #1;
        if (data_valid === 1'b1) begin
            n_valid++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_valid got dataout=%h with no pending read", dataout);
            end else begin
                exp_d = sb.pop_front();
                if (dataout !== exp_d) begin
                    errors++;
                    $display("FAIL sb_dataout got=%h expected=%h", dataout, exp_d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge io_clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [31:0] a, input logic [31:0] exp_v);
        addr           = a;
        read_io_enable = 1'b1;
        sb.push_back(exp_v);
        n_strobe++;
    endtask

    task automatic idle();
        read_io_enable = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        checks++;
        if (dataout !== 32'h0 || data_valid !== 1'b0 || changed !== 3'b000) begin
            errors++;
            $display("FAIL reset_state got dout=%h dv=%b chg=%b expected 0/0/000", dataout, data_valid, changed);
        end
        step(LAT + 4);
        checks++;
        if (changed !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle_flags got=%b expected=000", changed);
        end
    endtask

    task automatic test_port_read();
        in_port1 = 32'h0000_00A5;
        step(30);
        strobe(32'h0000_00C4, 32'h0000_00A5);
        step();
        idle();
        checks++;
        if (data_valid !== 1'b1) begin
            errors++;
            $display("FAIL port_read_valid got=%b expected=1", data_valid);
        end
        step();
        checks++;
        if (data_valid !== 1'b0 || dataout !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL port_read_pulse got dv=%b dout=%h expected dv=0 dout=000000a5", data_valid, dataout);
        end
        checks++;
        if (changed !== 3'b010) begin
            errors++;
            $display("FAIL port_read_flags got=%b expected=010", changed);
        end
    endtask

    task automatic test_change_latency();
        in_port0 = 32'h1;
        step();
        step(LAT - 2);
        strobe(32'h0000_00C0, 32'h0);
        step();
        checks++;
        if (changed[0] !== 1'b0) begin
            errors++;
            $display("FAIL latency_early got changed0=%b expected=0", changed[0]);
        end
        strobe(32'h0000_00C0, 32'h1);
        step();
        idle();
        checks++;
        if (changed !== 3'b011) begin
            errors++;
            $display("FAIL latency_edge got=%b expected=011", changed);
        end
        step();
    endtask

    task automatic test_glitch();
        logic [2:0] exp_chg;
        exp_chg = DEB ? 3'b011 : 3'b111;
        in_port2 = 32'h0000_FFFF;
        step(10);
        in_port2 = 32'h0;
        step(30);
        checks++;
        if (changed !== exp_chg) begin
            errors++;
            $display("FAIL glitch_flags got=%b expected=%b", changed, exp_chg);
        end
        strobe(32'h0000_00C8, 32'h0);
        step();
        idle();
        step();
    endtask

    task automatic test_status();
        strobe(32'h0000_00CC, DEB ? 32'h3 : 32'h7);
        step();
        idle();
        checks++;
        if (changed !== 3'b000) begin
            errors++;
            $display("FAIL status_clear got=%b expected=000", changed);
        end
        in_port0 = 32'h2;
        in_port1 = 32'h5A;
        step(LAT + 3);
        checks++;
        if (changed !== 3'b011) begin
            errors++;
            $display("FAIL status_setup got=%b expected=011", changed);
        end
        // Port-2 acceptance lands on the same edge as the status read.
        in_port2 = 32'h7;
        step(LAT);
        strobe(32'h0000_00CC, 32'h3);
        step();
        idle();
        checks++;
        if (changed !== 3'b100) begin
            errors++;
            $display("FAIL status_race got=%b expected=100", changed);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int start_valid;
        start_valid = n_valid;
        strobe(32'h0000_00C0, 32'h2);
        step();
        strobe(32'h0000_00C4, 32'h5A);
        step();
        strobe(32'h0000_00C8, 32'h7);
        step();
        strobe(32'h0000_00CC, 32'h4);
        step();
        strobe(32'h0000_0090, 32'h0);
        step();
        strobe(32'h0000_00CC, 32'h0);
        step();
        idle();
        step(2);
        checks++;
        if (n_valid - start_valid !== 6) begin
            errors++;
            $display("FAIL b2b_pulses got=%0d expected=6", n_valid - start_valid);
        end
    endtask

    task automatic test_unmapped_hold();
        strobe(32'h0000_00C4, 32'h5A);
        step();
        strobe(32'h0000_0090, 32'h0);
        step();
        idle();
        checks++;
        if (data_valid !== 1'b1 || dataout !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_read got dv=%b dout=%h expected dv=1 dout=0", data_valid, dataout);
        end
        strobe(32'h0000_00C4, 32'h5A);
        step();
        idle();
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (data_valid !== 1'b0 || dataout !== 32'h5A) begin
                errors++;
                $display("FAIL hold_cycle%0d got dv=%b dout=%h expected dv=0 dout=0000005a", i, data_valid, dataout);
            end
        end
    endtask

    task automatic test_mid_reset();
        strobe(32'h0000_00C0, 32'h2);
        step();
        strobe(32'h0000_00C4, 32'h5A);
        step();
        // This strobe coincides with reset and must produce no pulse.
        reset          = 1'b1;
        addr           = 32'h0000_00C8;
        read_io_enable = 1'b1;
        step();
        checks++;
        if (dataout !== 32'h0 || data_valid !== 1'b0 || changed !== 3'b000) begin
            errors++;
            $display("FAIL midreset_state got dout=%h dv=%b chg=%b expected 0/0/000", dataout, data_valid, changed);
        end
        reset = 1'b0;
        strobe(32'h0000_00CC, 32'h0);
        step();
        strobe(32'h0000_00C4, 32'h0);
        step();
        idle();
        step(LAT + 4);
        checks++;
        if (changed !== 3'b111) begin
            errors++;
            $display("FAIL midreset_reaccept got=%b expected=111", changed);
        end
    endtask

    initial begin
        test_reset();
        test_port_read();
        test_change_latency();
        test_glitch();
        test_status();
        test_back_to_back();
        test_unmapped_hold();
        test_mid_reset();
        step(2);
        checks++;
        if (sb.size() != 0 || n_valid != n_strobe) begin
            errors++;
            $display("FAIL pulse_accounting got pending=%0d pulses=%0d expected pending=0 pulses=%0d",
                     sb.size(), n_valid, n_strobe);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
